regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREG, default 32, register count (power of two, 2..64); AW = $clog2(NREG) is derived.
REQ-003 SHALL have parameter NRP, default 2, number of read ports (1..4).
REQ-004 SHALL have port Clk  input  1  rising-edge clock, the only clock.
REQ-005 SHALL have port Rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port raddr  input  NRP*AW  read addresses; port i is bits [i*AW +: AW].
REQ-007 SHALL have port rdata  output  NRP*XLEN  read data, one XLEN slice per port.
REQ-008 SHALL have port rbusy  output  NRP  per port: the addressed register has a pending producer.
REQ-009 SHALL have port RegWrite  input  1  writeback strobe.
REQ-010 SHALL have port waddr  input  AW  writeback address.
REQ-011 SHALL have port wdata  input  XLEN  writeback data.
REQ-012 SHALL have port issue_valid  input  1  an instruction with a destination is issuing.
REQ-013 SHALL have port issue_rd  input  AW  destination of the issuing instruction.
REQ-014 SHALL have port issue_ready  output  1  issue accepted this cycle.
REQ-015 SHALL have port pend_cnt  output  $clog2(NREG+1)  number of set pending bits.

Function
REQ-016 Register 0 SHALL read as zero; writes and issues to it SHALL have no state effect.
REQ-017 Writes SHALL commit on the rising Clk edge when RegWrite=1 and waddr!=0.
REQ-018 Reads SHALL be combinational from the array: zero read latency, one cycle write-to-read latency unless REQ-031 applies.
REQ-019 A pending bit per register SHALL be set at the edge where issue_valid and issue_ready are both 1 and issue_rd!=0.
REQ-020 A pending bit SHALL be cleared at the edge where RegWrite=1 and waddr selects it.
REQ-021 A writeback to a non-pending register SHALL update data and leave all pending bits unchanged.
REQ-022 issue_ready SHALL be 0 when pending[issue_rd]=1 (WAW stall) and 1 otherwise; issue_ready SHALL be 1 for issue_rd=0.
REQ-023 A same-cycle writeback clearing pending[issue_rd] SHALL NOT raise issue_ready in that cycle.
REQ-024 An accepted issue and a writeback to different registers in the same cycle SHALL both take effect.
REQ-025 rbusy[i] SHALL equal pending[raddr_i]; rbusy[i] SHALL be 0 when raddr_i=0.
REQ-026 pend_cnt SHALL be a registered counter: +1 on set only, -1 on clear only, unchanged on both or neither; it SHALL never wrap.

Reset
REQ-027 With Rst=1 at a rising edge, all registers, all pending bits and pend_cnt SHALL become 0.
REQ-028 During reset, rdata SHALL read 0, rbusy 0 and issue_ready 1; issue and writeback inputs SHALL be ignored.
REQ-029 Reset asserted while registers are pending SHALL drop all pending bits with no writeback.

Configuration
REQ-030 Macro REGFILE_BYPASS_EN SHALL select write-to-read forwarding.
REQ-031 With it defined: when RegWrite=1, waddr!=0 and waddr equals raddr_i, rdata_i SHALL be wdata and rbusy_i SHALL be 0 in the same cycle.
REQ-032 Without it: that port SHALL return the old value and its old pending bit until the next cycle.

Structure
REQ-033 Package regfile_pkg SHALL hold the default XLEN and NREG values and the data and address typedefs.
REQ-034 Pending bits and pend_cnt SHALL live in sub-module regfile_scoreboard; the data array and read muxes SHALL live in regfile_sb.

Verification
REQ-035 After reset, write x5=0xDEADBEEF, read port 0 at x5 one cycle later -> 0xDEADBEEF; read x0 -> 0.
REQ-036 Issue rd=7 -> rbusy=1 for x7 and pend_cnt=1; writeback x7=0x12 -> rbusy=0, pend_cnt=0, data 0x12.
REQ-037 Issue rd=7 while x7 is pending -> issue_ready=0 and pend_cnt unchanged; in the same cycle as a writeback to x7 -> still 0.
REQ-038 Issue rd=3 and writeback x9 in the same cycle, with x9 pending -> pend_cnt unchanged, x3 busy, x9 free.
REQ-039 With REGFILE_BYPASS_EN, same-cycle write x4=0x55 and read x4 -> rdata=0x55, rbusy=0; without the macro -> old value.
REQ-040 Issue x1, x2 and x3, then assert Rst -> pend_cnt=0, all reads 0, issue_ready=1.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg -- shared constants and types for the scoreboarded register file.
//   XLEN_DEF / NREG_DEF / NRP_DEF : default data width, register count, read ports
//   data_t / addr_t               : data word and register address at default sizes
package regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int NRP_DEF  = 2;

  typedef logic [XLEN_DEF-1:0]         data_t;
  typedef logic [$clog2(NREG_DEF)-1:0] addr_t;

endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb_if -- bundle of the register file's read, writeback and issue signals.
//   raddr/rdata/rbusy           : NRP read ports, flattened, port i at slice i
//   RegWrite/waddr/wdata        : writeback port
//   issue_valid/issue_rd        : issuing instruction and its destination
//   issue_ready                 : issue accepted this cycle
//   pend_cnt                    : number of registers with a pending producer
// modport master drives requests (pipeline side); modport slave is the register file.
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRP  = NRP_DEF
);
  localparam int AW = $clog2(NREG);
  localparam int CW = $clog2(NREG + 1);

  logic [NRP*AW-1:0]   raddr;
  logic [NRP*XLEN-1:0] rdata;
  logic [NRP-1:0]      rbusy;
  logic                RegWrite;
  logic [AW-1:0]       waddr;
  logic [XLEN-1:0]     wdata;
  logic                issue_valid;
  logic [AW-1:0]       issue_rd;
  logic                issue_ready;
  logic [CW-1:0]       pend_cnt;

  modport master (
    output raddr, RegWrite, waddr, wdata, issue_valid, issue_rd,
    input  rdata, rbusy, issue_ready, pend_cnt
  );

  modport slave (
    input  raddr, RegWrite, waddr, wdata, issue_valid, issue_rd,
    output rdata, rbusy, issue_ready, pend_cnt
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard -- one pending bit per register plus a population counter.
//   Clk, Rst              : clock, synchronous active-high reset
//   issue_valid/issue_rd  : issuing instruction with a destination
//   wb_valid/wb_addr      : writeback strobe and address
//   issue_ready           : low while the destination already has a pending producer
//   pend_cnt              : registered count of set pending bits
//   pending               : raw pending vector (bit 0 is always clear)
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  localparam int AW  = $clog2(NREG),
  localparam int CW  = $clog2(NREG + 1)
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_addr,
  output logic            issue_ready,
  output logic [CW-1:0]   pend_cnt,
  output logic [NREG-1:0] pending
);

  logic [NREG-1:0] pending_reg, pending_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            set_hit, clr_hit;

  // Ready looks only at the registered bit, so a writeback freeing the
  // destination in this same cycle cannot release the stall early.
  assign issue_ready = Rst || !pending_reg[issue_rd];

  assign set_hit = issue_valid && issue_ready && (issue_rd != '0);
  // Only a writeback to a register that is actually pending counts as a clear.
  assign clr_hit = wb_valid && (wb_addr != '0) && pending_reg[wb_addr];

  // set_hit needs the target clear and clr_hit needs it set, so both can
  // never address the same register in one cycle.
  always_comb begin
    pending_next = pending_reg;
    if (clr_hit) pending_next[wb_addr] = 1'b0;
    if (set_hit) pending_next[issue_rd] = 1'b1;

    cnt_next = cnt_reg;
    if (set_hit && !clr_hit && (cnt_reg != CW'(NREG - 1))) begin
      cnt_next = cnt_reg + 1'b1;
    end else if (clr_hit && !set_hit && (cnt_reg != '0)) begin
      cnt_next = cnt_reg - 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      pending_reg <= '0;
      cnt_reg     <= '0;
    end else begin
      pending_reg <= pending_next;
      cnt_reg     <= cnt_next;
    end
  end

  assign pend_cnt = cnt_reg;
  assign pending  = pending_reg;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb -- multi-port register file with a producer scoreboard.
//   Clk, Rst : clock, synchronous active-high reset
//   bus      : regfile_sb_if.slave (read ports, writeback, issue handshake, pend_cnt)
// Reads are combinational from the array; x0 always reads zero and is never busy.
// Build option: define REGFILE_BYPASS_EN to forward a same-cycle writeback to
// any read port addressing the written register (data = wdata, busy = 0).
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRP  = NRP_DEF
) (
  input  logic        Clk,
  input  logic        Rst,
  regfile_sb_if.slave bus
);

  localparam int AW = $clog2(NREG);
  localparam int CW = $clog2(NREG + 1);

  logic [XLEN-1:0] regs_reg [NREG];
  logic [NREG-1:0] pending;
  logic            issue_ready;
  logic [CW-1:0]   pend_cnt;
  logic [NRP*XLEN-1:0] rdata_all;
  logic [NRP-1:0]      rbusy_all;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < NREG; i++) regs_reg[i] <= '0;
    end else if (bus.RegWrite && (bus.waddr != '0)) begin
      regs_reg[bus.waddr] <= bus.wdata;
    end
  end

  regfile_scoreboard #(.NREG(NREG)) u_scoreboard (
    .Clk        (Clk),
    .Rst        (Rst),
    .issue_valid(bus.issue_valid),
    .issue_rd   (bus.issue_rd),
    .wb_valid   (bus.RegWrite),
    .wb_addr    (bus.waddr),
    .issue_ready(issue_ready),
    .pend_cnt   (pend_cnt),
    .pending    (pending)
  );

  for (genvar gi = 0; gi < NRP; gi++) begin : g_rd
    logic [AW-1:0]   ra;
    logic            hit;
    logic [XLEN-1:0] data;
    logic            busy;

    assign ra = bus.raddr[gi*AW +: AW];

`ifdef REGFILE_BYPASS_EN
    assign hit = bus.RegWrite && (bus.waddr != '0) && (bus.waddr == ra);
`else
    assign hit = 1'b0;
`endif

    always_comb begin
      data = regs_reg[ra];
      busy = pending[ra];
      if (Rst || (ra == '0)) begin
        data = '0;
        busy = 1'b0;
      end else if (hit) begin
        data = bus.wdata;
        busy = 1'b0;
      end
    end

    assign rdata_all[gi*XLEN +: XLEN] = data;
    assign rbusy_all[gi]              = busy;
  end

  assign bus.rdata       = rdata_all;
  assign bus.rbusy       = rbusy_all;
  assign bus.issue_ready = issue_ready;
  assign bus.pend_cnt    = pend_cnt;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb -- directed self-checking bench for regfile_sb (default parameters,
// NRP = 2). Expected values are hand-derived; same-cycle read-after-write
// expectations follow whether REGFILE_BYPASS_EN is defined for the build.
module tb_regfile_sb;
  import regfile_pkg::*;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRP  = 2;
  localparam int AW   = 5;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_sb_if #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP)) bus ();

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP)) dut (
    .Clk(clk),
    .Rst(rst),
    .bus(bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic note(input string msg);
    $display("txn t=%0t %s", $time, msg);
  endtask

  task automatic idle();
    bus.raddr       = '0;
    bus.RegWrite    = 1'b0;
    bus.waddr       = '0;
    bus.wdata       = '0;
    bus.issue_valid = 1'b0;
    bus.issue_rd    = '0;
  endtask

  task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    bus.raddr = {a1, a0};
  endtask

  task automatic wb(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    bus.RegWrite = 1'b1;
    bus.waddr    = a;
    bus.wdata    = d;
  endtask

  task automatic issue(input logic [AW-1:0] rd);
    bus.issue_valid = 1'b1;
    bus.issue_rd    = rd;
  endtask

  // Advance past the next rising edge; inputs change 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [XLEN-1:0] rd0, rd1;
  assign rd0 = bus.rdata[XLEN-1:0];
  assign rd1 = bus.rdata[2*XLEN-1:XLEN];

  initial begin
    idle();
    rst = 1'b1;

    // Reset with active issue/writeback inputs: outputs forced, inputs ignored.
    issue(5); wb(5, 32'hCAFE); set_ra(5, 0);
    #2;
    note("reset with active inputs");
    check_eq("rst_rdata0", rd0, 0);
    check_eq("rst_rbusy0", bus.rbusy[0], 0);
    check_eq("rst_issue_ready", bus.issue_ready, 1);
    tick(); tick();
    rst = 1'b0; idle(); set_ra(5, 0); #1;
    note("after reset");
    check_eq("post_rst_pend_cnt", bus.pend_cnt, 0);
    check_eq("post_rst_x5", rd0, 0);
    check_eq("post_rst_rbusy0", bus.rbusy[0], 0);
    check_eq("post_rst_ready", bus.issue_ready, 1);

    // Write x5, read back a cycle later; x0 stays zero.
    wb(5, 32'hDEADBEEF); set_ra(5, 0); #1;
    note("write x5=deadbeef");
    check_eq("x5_same_cycle", rd0, BYP ? 32'hDEADBEEF : 32'h0);
    tick(); idle(); set_ra(5, 0); #1;
    check_eq("x5_next_cycle", rd0, 32'hDEADBEEF);
    check_eq("x0_port1", rd1, 0);
    wb(0, 32'hFFFF_FFFF); set_ra(0, 5); #1;
    note("write x0 attempt");
    check_eq("x0_during_write", rd0, 0);
    tick(); idle(); set_ra(0, 5); #1;
    check_eq("x0_after_write", rd0, 0);
    check_eq("x5_port1", rd1, 32'hDEADBEEF);

    // Issue rd=7 then write it back.
    issue(7); #1;
    note("issue x7");
    check_eq("issue7_ready", bus.issue_ready, 1);
    tick(); idle(); set_ra(7, 0); #1;
    check_eq("x7_busy", bus.rbusy[0], 1);
    check_eq("x7_pend_cnt", bus.pend_cnt, 1);
    check_eq("x0_never_busy", bus.rbusy[1], 0);

    issue(7); set_ra(7, 0); #1;
    note("WAW issue x7");
    check_eq("waw_ready", bus.issue_ready, 0);
    tick(); idle(); #1;
    check_eq("waw_pend_cnt", bus.pend_cnt, 1);

    issue(7); wb(7, 32'h12); set_ra(7, 0); #1;
    note("WAW issue x7 with writeback x7=0x12");
    check_eq("waw_wb_ready", bus.issue_ready, 0);
    check_eq("x7_wb_busy_same", bus.rbusy[0], BYP ? 1'b0 : 1'b1);
    check_eq("x7_wb_data_same", rd0, BYP ? 32'h12 : 32'h0);
    tick(); idle(); set_ra(7, 0); #1;
    check_eq("x7_free", bus.rbusy[0], 0);
    check_eq("x7_wb_pend_cnt", bus.pend_cnt, 0);
    check_eq("x7_data", rd0, 32'h12);
    issue(7); #1;
    check_eq("x7_ready_again", bus.issue_ready, 1);
    idle();

    // Issue x3 and writeback pending x9 in the same cycle.
    issue(9); tick(); idle(); #1;
    note("issue x9");
    check_eq("x9_pend_cnt", bus.pend_cnt, 1);
    issue(3); wb(9, 32'h99); #1;
    note("issue x3 + writeback x9=0x99");
    check_eq("x3_ready", bus.issue_ready, 1);
    tick(); idle(); set_ra(3, 9); #1;
    check_eq("swap_pend_cnt", bus.pend_cnt, 1);
    check_eq("x3_busy", bus.rbusy[0], 1);
    check_eq("x9_free", bus.rbusy[1], 0);
    check_eq("x9_data", rd1, 32'h99);

    // Writeback to a non-pending register leaves the scoreboard alone.
    wb(10, 32'hA); tick(); idle(); set_ra(10, 3); #1;
    note("writeback non-pending x10");
    check_eq("x10_pend_cnt", bus.pend_cnt, 1);
    check_eq("x10_data", rd0, 32'hA);
    check_eq("x3_still_busy", bus.rbusy[1], 1);

    // Issue to x0 has no effect.
    issue(0); #1;
    note("issue x0");
    check_eq("x0_issue_ready", bus.issue_ready, 1);
    tick(); idle(); set_ra(0, 3); #1;
    check_eq("x0_issue_pend_cnt", bus.pend_cnt, 1);
    check_eq("x0_issue_busy", bus.rbusy[0], 0);

    wb(3, 32'h33); tick(); idle(); #1;
    note("writeback x3");
    check_eq("x3_clear_pend_cnt", bus.pend_cnt, 0);

    // Same-cycle write and read of a pending register.
    wb(4, 32'h44); tick(); idle();
    issue(4); tick(); idle();
    wb(4, 32'h55); set_ra(4, 4); #1;
    note("writeback x4=0x55 with read x4");
    check_eq("x4_fwd_data", rd0, BYP ? 32'h55 : 32'h44);
    check_eq("x4_fwd_busy", bus.rbusy[0], BYP ? 1'b0 : 1'b1);
    tick(); idle(); set_ra(4, 0); #1;
    check_eq("x4_data", rd0, 32'h55);
    check_eq("x4_free", bus.rbusy[0], 0);
    check_eq("x4_pend_cnt", bus.pend_cnt, 0);

    // Reset with several registers pending.
    issue(1); tick(); issue(2); tick(); issue(3); tick(); idle(); set_ra(5, 1); #1;
    note("issued x1 x2 x3");
    check_eq("three_pend_cnt", bus.pend_cnt, 3);
    check_eq("x1_busy", bus.rbusy[1], 1);
    rst = 1'b1; issue(1); wb(2, 32'h77); set_ra(5, 1); #1;
    note("reset while pending");
    check_eq("rst2_x5", rd0, 0);
    check_eq("rst2_x1_busy", bus.rbusy[1], 0);
    check_eq("rst2_ready", bus.issue_ready, 1);
    tick(); rst = 1'b0; idle(); set_ra(5, 1); bus.issue_rd = 1; #1;
    check_eq("rst2_pend_cnt", bus.pend_cnt, 0);
    check_eq("rst2_x5_cleared", rd0, 0);
    check_eq("rst2_x1_free", bus.rbusy[1], 0);
    check_eq("rst2_ready_after", bus.issue_ready, 1);
    set_ra(2, 4); #1;
    check_eq("rst2_x2", rd0, 0);
    check_eq("rst2_x4", rd1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
